// File: rtl/dbus_responder_pkg.sv
// Shared address map, CON_STAT field positions and region decode type
// for the core data-port responder.
package dbus_responder_pkg;

    localparam logic [31:0] MMIO_BASE    = 32'h1000_0000;
    localparam logic [31:0] CON_TX_OFF   = 32'h0000_0000;
    localparam logic [31:0] CON_STAT_OFF = 32'h0000_0004;
    localparam logic [31:0] MTIME_OFF    = 32'h0000_0008;
    localparam logic [31:0] TOHOST_OFF   = 32'h0000_000C;

    localparam int CS_FULL_BIT  = 0;
    localparam int CS_EMPTY_BIT = 1;
    localparam int CS_OVF_BIT   = 2;
    localparam int CS_COUNT_LSB = 4;
    localparam int CS_COUNT_MSB = 7;
    localparam int CS_COUNT_W   = CS_COUNT_MSB - CS_COUNT_LSB + 1;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_CON_TX,
        REG_CON_STAT,
        REG_MTIME,
        REG_TOHOST,
        REG_NONE
    } region_e;

endpackage

// File: rtl/dbus_responder_tx_fifo.sv
// Console TX byte FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable; the caller qualifies push against full.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; a push into the slot being popped is safe
    // because head is read combinationally before the edge.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/dbus_responder.sv
// Zero-wait-state data-port responder: word RAM, console TX FIFO, free-running
// timer and TOHOST register. Reads are combinational, writes commit at the edge.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 4096,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  con_valid_o,
    output logic [7:0]            con_data_o,
    input  logic                  con_ready_i,
    output logic [DATA_WIDTH-1:0] tohost_o,
    output logic                  tohost_valid_o
);
    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] RAM_BYTES = ADDR_WIDTH'(RAM_DEPTH * 4);

    region_e               region;
    logic [ADDR_WIDTH-1:0] word_addr;

    always_comb begin
        word_addr = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        region    = REG_NONE;
        if (addr_i < RAM_BYTES)
            region = REG_RAM;
        else if (word_addr == ADDR_WIDTH'(MMIO_BASE + CON_TX_OFF))
            region = REG_CON_TX;
        else if (word_addr == ADDR_WIDTH'(MMIO_BASE + CON_STAT_OFF))
            region = REG_CON_STAT;
        else if (word_addr == ADDR_WIDTH'(MMIO_BASE + MTIME_OFF))
            region = REG_MTIME;
        else if (word_addr == ADDR_WIDTH'(MMIO_BASE + TOHOST_OFF))
            region = REG_TOHOST;
    end

    logic wr_ram, wr_tx, wr_stat, wr_mtime, wr_tohost;
    assign wr_ram    = we_i && (region == REG_RAM);
    assign wr_tx     = we_i && (region == REG_CON_TX);
    assign wr_stat   = we_i && (region == REG_CON_STAT);
    assign wr_mtime  = we_i && (region == REG_MTIME);
    assign wr_tohost = we_i && (region == REG_TOHOST);

    logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RAM_AW-1:0]     ram_idx;
    assign ram_idx = addr_i[RAM_AW+1:2];

    always_ff @(posedge clk_i) begin
        if (wr_ram) ram[ram_idx] <= data_i;
    end

    logic          fifo_full, fifo_empty, push, pop, drop, overflow;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;

    // A push against a full FIFO still lands if a pop frees a slot this cycle.
    assign pop  = !fifo_empty && con_ready_i;
    assign push = wr_tx && (!fifo_full || pop);
    assign drop = wr_tx && !push;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (data_i[7:0]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign con_valid_o = !fifo_empty;
    assign con_data_o  = fifo_empty ? 8'h00 : fifo_head;

    // Set beats a same-cycle W1C so a dropped byte is never silently lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (wr_stat && data_i[CS_OVF_BIT])
            overflow <= 1'b0;
    end

    logic [DATA_WIDTH-1:0] mtime;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            mtime <= '0;
        else if (wr_mtime)
            mtime <= data_i;
        else
            mtime <= mtime + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tohost_o       <= '0;
            tohost_valid_o <= 1'b0;
        end else if (wr_tohost) begin
            tohost_o <= data_i;
            if (data_i != '0) tohost_valid_o <= 1'b1;
        end
    end

    logic [DATA_WIDTH-1:0] stat;

    always_comb begin
        stat = '0;
        stat[CS_FULL_BIT]  = fifo_full;
        stat[CS_EMPTY_BIT] = fifo_empty;
        stat[CS_OVF_BIT]   = overflow;
        stat[CS_COUNT_MSB:CS_COUNT_LSB] = CS_COUNT_W'(fifo_count);
    end

    always_comb begin
        data_o = '0;
        case (region)
            REG_RAM:      data_o = ram[ram_idx];
            REG_CON_STAT: data_o = stat;
            REG_MTIME:    data_o = mtime;
            REG_TOHOST:   data_o = tohost_o;
            default:      data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: register/RAM reads checked by immediate
// assertions, console bytes checked through a push-on-write / pop-on-drain queue.
module tb_dbus_responder;

    localparam logic [31:0] A_TX   = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0004;
    localparam logic [31:0] A_MT   = 32'h1000_0008;
    localparam logic [31:0] A_TH   = 32'h1000_000C;

    logic        clk, rst, we, con_ready;
    logic [31:0] addr, din, data_o, tohost;
    logic        con_valid, tohost_valid;
    logic [7:0]  con_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] byte_q[$];

    dbus_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RAM_DEPTH  (4096),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .we_i           (we),
        .addr_i         (addr),
        .data_i         (din),
        .data_o         (data_o),
        .con_valid_o    (con_valid),
        .con_data_o     (con_data),
        .con_ready_i    (con_ready),
        .tohost_o       (tohost),
        .tohost_valid_o (tohost_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic byte_cmp(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        n_cmp++;
        if (byte_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %h expected no byte", tag, obs);
        end else begin
            e = byte_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we   = w;
        addr = a;
        din  = d;
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        step(1'b1, A_TX, {24'h0, b});
        byte_q.push_back(b);
    endtask

    task automatic drain(input string tag, input int n);
        int popped = 0;
        for (int i = 0; i < n + 4; i++) begin
            @(negedge clk);
            we        = 1'b0;
            addr      = A_STAT;
            con_ready = 1'b1;
            #1;
            if (!con_valid) break;
            byte_cmp(tag, con_data);
            popped++;
        end
        con_ready = 1'b0;
        chk({tag, "_count"}, popped, n);
        chk({tag, "_empty"}, {31'h0, con_valid}, 32'h0);
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; addr = '0; din = '0; con_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_con_valid", {31'h0, con_valid}, 32'h0);
        chk("rst_con_data", {24'h0, con_data}, 32'h0);
        chk("rst_tohost", tohost, 32'h0);
        chk("rst_tohost_valid", {31'h0, tohost_valid}, 32'h0);
        addr = A_STAT; #1;
        chk("rst_stat", data_o, 32'h0000_0002);
        step(1'b0, A_MT, 32'h0);
        rst = 1'b0;
        chk("mtime_at_release", data_o, 32'h0);
        step(1'b0, A_MT, 32'h0);
        chk("mtime_after_release", data_o, 32'h1);

        // Mid-run reset with three bytes queued and mtime at 0x55
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        step(1'b1, A_TH, 32'h1);
        step(1'b1, A_MT, 32'h55);
        step(1'b0, A_MT, 32'h0);
        chk("pre_rst_mtime", data_o, 32'h55);
        chk("pre_rst_valid", {31'h0, con_valid}, 32'h1);
        chk("pre_rst_tohost_valid", {31'h0, tohost_valid}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_con_valid", {31'h0, con_valid}, 32'h0);
        chk("midrst_con_data", {24'h0, con_data}, 32'h0);
        chk("midrst_mtime", data_o, 32'h0);
        chk("midrst_tohost_valid", {31'h0, tohost_valid}, 32'h0);
        chk("midrst_tohost", tohost, 32'h0);
        byte_q.delete();
        step(1'b0, A_MT, 32'h0);
        rst = 1'b0;
        chk("midrst_release_mtime", data_o, 32'h0);
        step(1'b0, A_MT, 32'h0);
        chk("midrst_mtime_plus1", data_o, 32'h1);
        step(1'b0, A_STAT, 32'h0);
        chk("midrst_stat", data_o, 32'h0000_0002);

        // RAM: read-during-write, byte-offset alias, last word, past-end
        step(1'b1, 32'h0000_0000, 32'h0000_0A0A);
        step(1'b1, 32'h0000_0010, 32'h1111_1111);
        step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("ram_same_cycle_old", data_o, 32'h1111_1111);
        step(1'b0, 32'h0000_0010, 32'h0);
        chk("ram_next_cycle_new", data_o, 32'hDEAD_BEEF);
        step(1'b0, 32'h0000_0013, 32'h0);
        chk("ram_byte_offset", data_o, 32'hDEAD_BEEF);
        step(1'b1, 32'h0000_3FFC, 32'hCAFE_F00D);
        step(1'b0, 32'h0000_3FFC, 32'h0);
        chk("ram_last_word", data_o, 32'hCAFE_F00D);
        step(1'b1, 32'h0000_4000, 32'h0000_0BAD);
        chk("ram_past_end_read", data_o, 32'h0);
        step(1'b0, 32'h0000_0000, 32'h0);
        chk("ram_past_end_no_alias", data_o, 32'h0000_0A0A);

        // FIFO fill, overflow, drain
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        push_byte(8'h44);
        step(1'b0, A_STAT, 32'h0);
        chk("stat_full", data_o, 32'h0000_0041);
        step(1'b1, A_TX, 32'h0000_0045);
        step(1'b0, A_STAT, 32'h0);
        chk("stat_overflow", data_o, 32'h0000_0045);
        drain("drain_full", 4);
        step(1'b0, A_STAT, 32'h0);
        chk("stat_after_drain", data_o, 32'h0000_0006);

        // W1C: bit 2 clear needed, other bits ignored
        step(1'b1, A_STAT, 32'h0000_00FB);
        step(1'b0, A_STAT, 32'h0);
        chk("w1c_bit2_zero", data_o, 32'h0000_0006);
        step(1'b1, A_STAT, 32'h0000_0004);
        step(1'b0, A_STAT, 32'h0);
        chk("w1c_clear", data_o, 32'h0000_0002);

        // Push into a full FIFO while it pops
        push_byte(8'h61);
        push_byte(8'h62);
        push_byte(8'h63);
        push_byte(8'h64);
        @(negedge clk);
        we = 1'b1; addr = A_TX; din = 32'h0000_0050; con_ready = 1'b1;
        #1;
        byte_cmp("push_pop_head", con_data);
        byte_q.push_back(8'h50);
        @(negedge clk);
        we = 1'b0; addr = A_STAT; con_ready = 1'b0;
        #1;
        chk("push_pop_stat", data_o, 32'h0000_0041);
        drain("drain_push_pop", 4);

        // Timer wrap
        step(1'b1, A_MT, 32'hFFFF_FFFE);
        step(1'b0, A_MT, 32'h0);
        chk("mtime_fffe", data_o, 32'hFFFF_FFFE);
        step(1'b0, A_MT, 32'h0);
        chk("mtime_ffff", data_o, 32'hFFFF_FFFF);
        step(1'b0, A_MT, 32'h0);
        chk("mtime_wrap", data_o, 32'h0);

        // TOHOST sticky valid, unmapped space
        step(1'b1, A_TH, 32'h0);
        step(1'b0, A_TH, 32'h0);
        chk("tohost0_valid", {31'h0, tohost_valid}, 32'h0);
        step(1'b1, A_TH, 32'h1);
        step(1'b0, A_TH, 32'h0);
        chk("tohost1_value", tohost, 32'h1);
        chk("tohost1_valid", {31'h0, tohost_valid}, 32'h1);
        chk("tohost1_read", data_o, 32'h1);
        step(1'b1, A_TH, 32'h0);
        step(1'b0, A_TH, 32'h0);
        chk("tohost_back0_value", tohost, 32'h0);
        chk("tohost_back0_valid", {31'h0, tohost_valid}, 32'h1);
        step(1'b0, 32'h2000_0000, 32'h0);
        chk("unmapped_read", data_o, 32'h0);
        step(1'b0, A_TX, 32'h0);
        chk("con_tx_read", data_o, 32'h0);
        step(1'b1, 32'h2000_0000, 32'h1234_5678);
        step(1'b0, A_TH, 32'h0);
        chk("unmapped_write_tohost", data_o, 32'h0);
        step(1'b0, A_STAT, 32'h0);
        chk("unmapped_write_stat", data_o, 32'h0000_0002);
        step(1'b0, 32'h0000_0010, 32'h0);
        chk("unmapped_write_ram", data_o, 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Memory-side responder for the pipeline core's data port. It serves the core's `ram_we_o`, `ram_addr_o` and `ram_data_o` outputs and drives the core's `ram_data_i` input.
- Decodes each access to one of: word RAM, a console TX FIFO, a free-running timer, or a TOHOST register used by ISA tests.
- The core has no wait-state input, so every access completes in the same cycle:
  - reads are combinational;
  - writes commit on the next `clk_i` rising edge.

Parameters:
- ADDR_WIDTH, 32, address width (matches core `ADDR_WIDTH`).
- DATA_WIDTH, 32, data width (matches core `DATA_WIDTH`).
- RAM_DEPTH, 4096, number of 32-bit RAM words; power of 2.
- FIFO_DEPTH, 4, console TX FIFO entries; power of 2, at least 2.

Ports:
- clk_i, in, 1, clock; all state updates on the rising edge.
- rst_i, in, 1, reset; asynchronous, active-high.
- we_i, in, 1, write request from core (`ram_we_o`).
- addr_i, in, ADDR_WIDTH, byte address from core (`ram_addr_o`).
- data_i, in, DATA_WIDTH, write data from core (`ram_data_o`).
- data_o, out, DATA_WIDTH, read data to core (`ram_data_i`); combinational.
- con_valid_o, out, 1, console byte available.
- con_data_o, out, 8, console byte at FIFO head.
- con_ready_i, in, 1, console sink accepts the byte.
- tohost_o, out, DATA_WIDTH, last value written to TOHOST.
- tohost_valid_o, out, 1, sticky; set by any TOHOST write with nonzero data.

Behaviour:
- Reset is asynchronous. While `rst_i` is high:
  - FIFO pointers are 0 and the FIFO is empty;
  - `overflow` is 0;
  - `mtime` is 0;
  - `tohost_o` is 0 and `tohost_valid_o` is 0;
  - `con_valid_o` is 0 and `con_data_o` is 0.
- RAM contents are not reset. `data_o` follows decode during reset.
- Address map:
  - `addr_i[1:0]` is ignored; all accesses are whole-word. Sub-word handling belongs to the core's MEM stage.
  - RAM: `addr_i < RAM_DEPTH*4`; word index `addr_i[log2(RAM_DEPTH)+1:2]`.
  - MMIO base is 0x1000_0000:
    - +0x0 CON_TX
    - +0x4 CON_STAT
    - +0x8 MTIME
    - +0xC TOHOST
  - Any other address: reads return 0, writes are ignored.
- Reads (every cycle, combinational, independent of `we_i`):
  - RAM returns the array word.
  - CON_TX reads 0.
  - CON_STAT returns `{.., count[7:4], overflow[2], empty[1], full[0]}`; all other bits are 0.
  - MTIME returns the current `mtime`.
  - TOHOST returns `tohost_o`.
  - A read of a RAM word being written in the same cycle returns the OLD value; the new value is visible the next cycle.
- Writes (`we_i` = 1, commit at the edge):
  - RAM: stores `data_i`.
  - CON_TX: push request with byte `data_i[7:0]`.
  - CON_STAT: writing 1 to bit 2 clears `overflow`; all other bits are read-only.
  - MTIME: `mtime` takes the value `data_i` at the edge, then resumes incrementing the following cycle.
  - TOHOST: `tohost_o` takes `data_i`; `tohost_valid_o` is set if `data_i` ≠ 0 and never clears until reset.
- FIFO:
  - `con_valid_o` = !empty; `con_data_o` = head entry.
  - pop occurs when `con_valid_o` && `con_ready_i`.
  - push is accepted when !full, OR when full and a pop happens in the same cycle.
  - a rejected push is dropped and sets `overflow` (sticky).
  - a simultaneous push and pop keeps `count` unchanged.
  - pointers carry one extra bit; full = MSBs differ and indices are equal; pointers wrap naturally.
  - if an `overflow` set and a W1C clear land in the same cycle, the set wins.
- Timer: `mtime` increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0. A software write overrides the increment for that cycle.

Decomposition:
- Shared package holds:
  - MMIO base and offsets: `MMIO_BASE`, `CON_TX_OFF`, `CON_STAT_OFF`, `MTIME_OFF`, `TOHOST_OFF`;
  - CON_STAT bit positions;
  - the region-select enum: `{REG_RAM, REG_CON_TX, REG_CON_STAT, REG_MTIME, REG_TOHOST, REG_NONE}`.
- One sub-module, `tx_fifo`:
  - parameters: width 8, FIFO_DEPTH;
  - signals: push, pop, full, empty, count, head;
  - drop/overflow detection stays in the top level.

Test Plan:
1. Reset asserted mid-run with FIFO holding 3 bytes and `mtime`=0x55 → immediately `con_valid_o`=0, `mtime`=0, `tohost_valid_o`=0; after release `mtime` reads 1 one cycle later.
2. RAM write to 0x0000_0010 of 0xDEADBEEF with a same-cycle read of that address → old value returned; next cycle read → 0xDEADBEEF. Address 0x0000_0013 returns the same word.
3. Push 0x41, 0x42, 0x43, 0x44 with `con_ready_i`=0:
   - CON_STAT reads `full`=1, `count`=4;
   - a 5th push of 0x45 sets `overflow`=1 and the FIFO is unchanged;
   - raise `con_ready_i` → bytes 0x41..0x44 drain, one per cycle.
4. FIFO full with `con_ready_i`=1 and a push of 0x50 in the same cycle → push accepted, `count` stays 4, `overflow` stays 0. W1C of bit 2 after overflow → `overflow`=0.
5. Write MTIME = 0xFFFF_FFFE → reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000 on successive cycles.
6. TOHOST write of 0 → `tohost_valid_o` stays 0. Write 1 → `tohost_o`=1, `tohost_valid_o`=1. Write 0 → `tohost_o`=0, `tohost_valid_o` remains 1. Read of 0x2000_0000 → 0, and a write there has no effect.
